// File: rtl/polar_poly_area.sv
// polar_poly_area: polygon area from N_RAYS equally spaced radii, sum of r[i]*r[i+1] scaled by 0.5*sin(2*pi/N_RAYS).
// Optional POLY_AREA_ROUND_EN: round-half-up with saturation in the scale step instead of truncation.
module polar_poly_area #(
    parameter int W      = 16,
    parameter int N_RAYS = 3,
    parameter int SIN_K  = 56756,
    parameter int AW     = 2*W + $clog2(N_RAYS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  radius,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] area,
    output logic          busy
);
    localparam int IW = $clog2(N_RAYS);
    localparam logic [16:0]   K17      = 17'(SIN_K);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_RAYS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRAP    = 3'd2,
        S_SCALE   = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_first;
    logic [W-1:0]    r_prev;
    logic [IW-1:0]   r_idx;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   r_area;
    logic            r_out_valid;
    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_last;
    logic [W-1:0]    w_mul_b;
    logic [2*W-1:0]  w_prod;
    logic [AW-1:0]   w_term;
    logic [AW+16:0]  w_scaled;
    logic [AW-1:0]   w_area;
    logic            w_unused;

    // Handshake: a beat moves on a rising edge where valid && ready; ready is a pure state decode.
    assign in_ready   = rst && (r_state == S_IDLE || r_state == S_COLLECT);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_last     = (r_idx == LAST_IDX);

    // One shared multiplier: prev*radius while collecting, prev*first to close the polygon.
    assign w_mul_b  = (r_state == S_WRAP) ? r_first : radius;
    assign w_prod   = {{W{1'b0}}, r_prev} * {{W{1'b0}}, w_mul_b};
    assign w_term   = {{(AW-2*W){1'b0}}, w_prod};
    assign w_scaled = {17'd0, r_acc} * {{AW{1'b0}}, K17};

`ifdef POLY_AREA_ROUND_EN
    logic [AW+17:0] w_round;
    assign w_round  = {1'b0, w_scaled} + {{(AW+1){1'b0}}, 1'b1, 16'd0};
    assign w_area   = w_round[AW+17] ? {AW{1'b1}} : w_round[AW+16:17];
    assign w_unused = ^w_round[16:0];
`else
    assign w_area   = w_scaled[AW+16:17];
    assign w_unused = ^w_scaled[16:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_in_xfer) w_next = S_COLLECT;
            S_COLLECT: if (w_in_xfer && w_last) w_next = S_WRAP;
            S_WRAP:    w_next = S_SCALE;
            S_SCALE:   w_next = S_OUT;
            S_OUT:     if (w_out_xfer) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_first     <= '0;
            r_prev      <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_area      <= '0;
            r_out_valid <= 1'b0;
        end else if (abort) begin
            r_idx       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_in_xfer) begin
                    r_first <= radius;
                    r_prev  <= radius;
                    r_idx   <= IW'(1);
                    r_acc   <= '0;
                end
                S_COLLECT: if (w_in_xfer) begin
                    r_acc  <= r_acc + w_term;
                    r_prev <= radius;
                    r_idx  <= w_last ? '0 : r_idx + IW'(1);
                end
                S_WRAP:  r_acc <= r_acc + w_term;
                S_SCALE: begin
                    r_area      <= w_area;
                    r_out_valid <= 1'b1;
                end
                S_OUT:   if (w_out_xfer) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign area      = r_area;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_polar_poly_area.sv
// Bench for polar_poly_area: a 3-ray and a 4-ray instance share stimulus; a frame-level area model
// and an expected queue check every cycle, with directed frames plus randomized traffic.
module tb_polar_poly_area;
    localparam int W  = 16;
    localparam int AW = 34;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          abort;
    logic          in_valid;
    logic [W-1:0]  radius;
    logic          out_ready;
    logic          sel;
    logic          iv3, iv4;
    logic          ir3, ir4, ov3, ov4, bz3, bz4;
    logic [AW-1:0] ar3, ar4;
    logic          ir, ov, bz;
    logic [AW-1:0] ar;

    assign iv3 = in_valid && !sel;
    assign iv4 = in_valid && sel;
    assign ir  = sel ? ir4 : ir3;
    assign ov  = sel ? ov4 : ov3;
    assign bz  = sel ? bz4 : bz3;
    assign ar  = sel ? ar4 : ar3;

    polar_poly_area #(.W(W), .N_RAYS(3), .SIN_K(56756)) dut3 (
        .clk(clk), .rst(rst), .abort(abort), .in_valid(iv3), .in_ready(ir3), .radius(radius),
        .out_valid(ov3), .out_ready(out_ready), .area(ar3), .busy(bz3)
    );

    polar_poly_area #(.W(W), .N_RAYS(4), .SIN_K(65536)) dut4 (
        .clk(clk), .rst(rst), .abort(abort), .in_valid(iv4), .in_ready(ir4), .radius(radius),
        .out_valid(ov4), .out_ready(out_ready), .area(ar4), .busy(bz4)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int since_done = 0;
    int frames_out = 0;
    logic [AW-1:0] last_area = '0;
    logic [W-1:0]  col_q[$];
    logic [AW-1:0] exp_q[$];
    logic m_rdy, m_ov;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Area of one frame straight from the geometry: closed sum of neighbour products, then the sine scale.
    function automatic logic [AW-1:0] ref_area(input logic [W-1:0] r[$], input int n, input longint unsigned k);
        longint unsigned s;
        longint unsigned p;
        s = 0;
        for (int i = 0; i < n; i++) s += 64'(r[i]) * 64'(r[(i + 1) % n]);
`ifdef POLY_AREA_ROUND_EN
        p = (s * k + 64'd65536) >> 17;
        if (p > ((64'd1 << AW) - 1)) p = (64'd1 << AW) - 1;
`else
        p = (s * k) >> 17;
`endif
        return p[AW-1:0];
    endfunction

    // Scoreboard: compare visible state, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (exp_q.size() != 0) since_done++;
            m_rdy = (exp_q.size() == 0);
            m_ov  = (exp_q.size() != 0) && (since_done >= 3);
            check("in_ready", 64'(ir), 64'(m_rdy));
            check("out_valid", 64'(ov), 64'(m_ov));
            check("busy", 64'(bz), 64'((exp_q.size() != 0) || (col_q.size() != 0)));
            if (m_ov) check("area", 64'(ar), 64'(exp_q[0]));
            if (abort) begin
                col_q.delete();
                exp_q.delete();
            end else begin
                if (m_ov && out_ready) begin
                    last_area = exp_q.pop_front();
                    frames_out++;
                end
                if (in_valid && m_rdy) begin
                    col_q.push_back(radius);
                    if (col_q.size() == (sel ? 4 : 3)) begin
                        exp_q.push_back(ref_area(col_q, sel ? 4 : 3, sel ? 64'd65536 : 64'd56756));
                        col_q.delete();
                        since_done = 0;
                    end
                end
            end
        end
    end

    task automatic send_radius(input logic [W-1:0] r);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        radius = r;
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge clk);
            got = ir && !abort;
            @(posedge clk);
            #1;
        end
        if (got) acc_cyc = cyc;
        else check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_out();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) check("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame3(input logic [W-1:0] r);
        for (int i = 0; i < 3; i++) send_radius(r);
        in_valid = 1'b0;
        wait_out();
    endtask

    task automatic random_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: radius = '1;
                1: radius = W'($urandom);
                2: radius = W'($urandom_range(0, 15));
                default: radius = W'($urandom_range(0, 1000));
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            abort = ($urandom_range(0, 49) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        wait_out();
        if (col_q.size() != 0) begin
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
        end
    endtask

    initial begin
        int t0, t1, f0;
        rst = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        radius = '0;
        out_ready = 1'b1;
        sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready3", 64'(ir3), 64'd0);
        check("rst_out_valid3", 64'(ov3), 64'd0);
        check("rst_area3", 64'(ar3), 64'd0);
        check("rst_busy3", 64'(bz3), 64'd0);
        check("rst_out_valid4", 64'(ov4), 64'd0);
        check("rst_busy4", 64'(bz4), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(ir3), 64'd1);

        send_frame3(16'd100);
        check("area_100", 64'(last_area), 64'd12990);

        send_frame3(16'd1000);
`ifdef POLY_AREA_ROUND_EN
        check("area_1000", 64'(last_area), 64'd1299042);
`else
        check("area_1000", 64'(last_area), 64'd1299041);
`endif

        // Abort coinciding with the third radius drops the whole frame.
        f0 = frames_out;
        send_radius(16'd100);
        send_radius(16'd100);
        radius = 16'd100;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", 64'(bz), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_out", 64'(frames_out - f0), 64'd0);
        send_frame3(16'd100);
        check("after_abort_area", 64'(last_area), 64'd12990);
        check("after_abort_frames", 64'(frames_out - f0), 64'd1);

        // Asynchronous reset in the middle of a frame.
        send_radius(16'd7);
        send_radius(16'd7);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(ov), 64'd0);
        check("midrst_busy", 64'(bz), 64'd0);
        check("midrst_in_ready", 64'(ir), 64'd0);
        col_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_frame3(16'd7);
`ifdef POLY_AREA_ROUND_EN
        check("area_7", 64'(last_area), 64'd64);
`else
        check("area_7", 64'(last_area), 64'd63);
`endif

        // Back-to-back frames with in_valid held high.
        f0 = frames_out;
        send_radius(16'd5);
        t0 = acc_cyc;
        send_radius(16'd6);
        send_radius(16'd7);
        send_radius(16'd8);
        t1 = acc_cyc;
        send_radius(16'd9);
        send_radius(16'd10);
        in_valid = 1'b0;
        wait_out();
        check("b2b_period", 64'(t1 - t0), 64'd6);
        check("b2b_frames", 64'(frames_out - f0), 64'd2);

        random_phase(1500);

        // Four-ray instance with an output stall.
        sel = 1'b1;
        out_ready = 1'b0;
        send_radius(16'd2);
        send_radius(16'd3);
        send_radius(16'd4);
        send_radius(16'd5);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("n4_out_valid", 64'(ov), 64'd1);
        check("n4_area", 64'(ar), 64'd24);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("n4_stall_area", 64'(ar), 64'd24);
            check("n4_stall_in_ready", 64'(ir), 64'd0);
        end
        out_ready = 1'b1;
        wait_out();
        check("n4_last_area", 64'(last_area), 64'd24);

        random_phase(1500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
